axi_ircrx_fifo_control: RTL
===========================

# axi_ircrx_fifo_control

AXI4-lite controlled receive front end for the infrared/UART RX path with a parametrised receive FIFO, replacing single-byte buffering. The block takes bytes (or wider words) from the RX deserialiser over AXI4-stream, buffers up to C_FIFO_DEPTH entries, and lets the processor drain them through a pop-on-read data register. It also exposes the baud divisor, FIFO status, a sticky overflow flag and a level/overflow interrupt.

## Interface
- C_ADDR_WIDTH, 32, AXI4-lite address width
- C_DATA_WIDTH, 32, AXI4-lite data width (fixed 32 in this generation)
- C_RX_WIDTH, 8, AXIS data width, 1..16
- C_FIFO_DEPTH, 16, FIFO entries, power of two, 2..256; CW = log2(C_FIFO_DEPTH)+1 is the count width
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axi_aw*/w*/b*/ar*/r*  standard AXI4-lite slave; awaddr/araddr C_ADDR_WIDTH, wdata/rdata 32, wstrb 4, bresp/rresp 2 (always 2'b00)
- s_axis_tready  out  1  FIFO write ready
- s_axis_tdata  in  C_RX_WIDTH  received word
- s_axis_tvalid  in  1  received word valid
- mod_m  out  16  baud divisor to the RX deserialiser
- irq  out  1  level interrupt, registered

## Operation
- Register map (address bits [3:0]):
  - 0x00 CTRL: [15:0] baud (R/W, byte-masked by wstrb), [16] rx_en (R/W), [17] irq_en (R/W), [18] flush (W, self-clearing, reads 0)
  - 0x04 RXDR (R): non-empty read returns head word in [C_RX_WIDTH-1:0] with [31]=1 and pops; empty read returns 0, no pop
  - 0x08 STAT (R, bit 2 W1C): [0] empty, [1] full, [2] overflow sticky, [8+CW-1:8] count
  - 0x0C THRESH (R/W): [CW-1:0] level threshold; values above C_FIFO_DEPTH saturate to C_FIFO_DEPTH on write
  - Unmapped reads return 0; unmapped writes ignored.
- Write FSM: WRIDLE (awready=1) -> WRDATA on awvalid, address latched; WRDATA (wready=1) -> WRRESP on wvalid, register updated in that cycle; WRRESP (bvalid=1) -> WRIDLE on bready.
- Read FSM: RDIDLE (arready=1) -> RDDATA on arvalid, rdata captured from the address in the handshake cycle; RDDATA (rvalid=1) -> RDIDLE on rready. rdata holds until the next read handshake.
- FIFO: circular buffer, rd/wr pointers log2(depth) bits with natural wrap, count CW bits.
  - Push: tvalid && tready && rx_en && (!full || pop same cycle).
  - tvalid && tready && rx_en && full && no pop: beat dropped, overflow <- 1.
  - rx_en=0: beats accepted and discarded, no overflow.
  - Push and pop in the same cycle: count unchanged; works at full and, since RXDR samples the pre-push state, an empty-FIFO read returns 0 while the push is stored.
- Flush: pointers and count cleared in the W handshake cycle. Flush beats a concurrent push (beat discarded) and pop. Overflow is unaffected; rx_en/irq_en/baud take the same write's values.
- Overflow clear: STAT write with wdata[2]=1 and wstrb[0]=1. A new overflow in the same cycle wins (stays 1).
- irq (registered) <- irq_en && ((count_next != 0 && count_next >= THRESH) || overflow_next).
- mod_m = CTRL[15:0] combinationally.

## Timing
- Reset values: all FSMs idle, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rdata=0, CTRL=0 (mod_m=0, rx_en=0, irq_en=0), THRESH=1, count=0, overflow=0, irq=0, s_axis_tready=0.
- s_axis_tready is a register set to 1 on the first clock after reset release and held at 1 (the deserialiser cannot stall).
- Read latency: rvalid rises 1 cycle after the ar handshake. The pop takes effect on the same edge, so STAT read back-to-back reflects it.
- Write-to-effect: a register changes on the edge ending the W handshake. bvalid rises the following cycle.
- irq updates 1 cycle after the causing push, pop, flush or clear.
- Reset asserted mid-transaction aborts it: FIFO contents are lost, and the AXI master must reissue.

## Test plan
- Reset, then read 0x00/0x08/0x0C -> 0x0, 0x1 (empty), 0x1. s_axis_tready goes to 1 one cycle after reset release.
- Write CTRL=0x0003_0364, then push 0xA5, 0x5A -> mod_m=0x0364, STAT count=2, irq=1. RXDR reads 0x8000_00A5 then 0x8000_005A, then 0x0. Count returns to 0 and irq=0.
- Depth 16, rx_en=1: push 17 beats (0x00..0x10) -> full=1, overflow=1, and all 16 reads return 0x00..0x0F.
- Write STAT=0x4 -> overflow cleared.
- Full FIFO with an RXDR pop in the same cycle as push 0x77 -> no overflow, count stays 16, and 0x77 is last out.
- THRESH=4, irq_en=1: irq stays 0 through 3 pushes and goes to 1 on the 4th. Flush -> count=0 and irq=0 one cycle later.
- rx_en=0 with 5 beats pushed -> count=0, overflow=0.

Source files
------------

// File: rtl/axi_ircrx_fifo_control.sv
// axi_ircrx_fifo_control
// AXI4-lite register front end for the IR/UART receive path. Received words
// arrive on an AXI4-stream slave and are buffered in a circular FIFO. The
// processor drains the FIFO through a pop-on-read data register, programs the
// baud divisor and level threshold, and watches a sticky overflow flag and a
// level/overflow interrupt.
module axi_ircrx_fifo_control #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_RX_WIDTH   = 8,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  // AXI4-lite write address channel
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  // AXI4-lite write data channel
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  // AXI4-lite write response channel
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // AXI4-lite read address channel
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  // AXI4-lite read data channel
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  // AXI4-stream receive words from the deserialiser
  output logic                      s_axis_tready,
  input  logic [C_RX_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  // Baud divisor and interrupt
  output logic [15:0]               mod_m,
  output logic                      irq
);

  localparam int AW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_RXDR   = 4'h4;
  localparam logic [3:0] ADDR_STAT   = 4'h8;
  localparam logic [3:0] ADDR_THRESH = 4'hC;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

  // Threshold writes larger than the FIFO can ever hold clamp to the depth.
  function automatic logic [CW-1:0] sat_thresh(input logic [C_DATA_WIDTH-1:0] v);
    if (v > C_DATA_WIDTH'(C_FIFO_DEPTH))
      return CW'(C_FIFO_DEPTH);
    else
      return v[CW-1:0];
  endfunction

  wr_state_t             wr_state, wr_state_next;
  rd_state_t             rd_state, rd_state_next;
  logic [3:0]            waddr;

  logic [15:0]           baud, baud_next;
  logic                  rx_en, rx_en_next;
  logic                  irq_en, irq_en_next;
  logic                  flush;
  logic [CW-1:0]         thresh, thresh_next;

  logic [C_RX_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, wr_ptr_next;
  logic [AW-1:0]         rd_ptr, rd_ptr_next;
  logic [CW-1:0]         count, count_next;
  logic                  overflow, overflow_next;
  logic                  irq_next;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_ctrl, wr_stat, wr_thresh;
  logic                  empty, full;
  logic                  beat, pop_req, pop, push, ovf_set, ovf_clr;
  logic [C_DATA_WIDTH-1:0] rd_mux;
  logic                  unused_bits;

  assign unused_bits = ^{s_axi_awaddr[C_ADDR_WIDTH-1:4],
                         s_axi_araddr[C_ADDR_WIDTH-1:4],
                         s_axi_wstrb[3]};

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign mod_m       = baud;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Write channel state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) wr_state <= WRIDLE;
    else        wr_state <= wr_state_next;
  end

  // Write channel next state and handshake outputs
  always_comb begin
    wr_state_next = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state)
      WRIDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) wr_state_next = WRDATA;
      end
      WRDATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) wr_state_next = WRRESP;
      end
      WRRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_next = WRIDLE;
      end
      default: wr_state_next = WRIDLE;
    endcase
  end

  // Latch the register offset of the pending write
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)     waddr <= 4'h0;
    else if (aw_hs) waddr <= s_axi_awaddr[3:0];
  end

  // Read channel state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rd_state <= RDIDLE;
    else        rd_state <= rd_state_next;
  end

  // Read channel next state and handshake outputs
  always_comb begin
    rd_state_next = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rd_state)
      RDIDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) rd_state_next = RDDATA;
      end
      RDDATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rd_state_next = RDIDLE;
      end
      default: rd_state_next = RDIDLE;
    endcase
  end

  assign wr_ctrl   = w_hs && (waddr == ADDR_CTRL);
  assign wr_stat   = w_hs && (waddr == ADDR_STAT);
  assign wr_thresh = w_hs && (waddr == ADDR_THRESH);

  // Control/threshold register updates with byte masking on CTRL
  always_comb begin
    baud_next   = baud;
    rx_en_next  = rx_en;
    irq_en_next = irq_en;
    flush       = 1'b0;
    thresh_next = thresh;
    if (wr_ctrl) begin
      if (s_axi_wstrb[0]) baud_next[7:0]  = s_axi_wdata[7:0];
      if (s_axi_wstrb[1]) baud_next[15:8] = s_axi_wdata[15:8];
      if (s_axi_wstrb[2]) begin
        rx_en_next  = s_axi_wdata[16];
        irq_en_next = s_axi_wdata[17];
        flush       = s_axi_wdata[18];
      end
    end
    if (wr_thresh) thresh_next = sat_thresh(s_axi_wdata);
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(C_FIFO_DEPTH));

  // A read of RXDR sees the FIFO as it was before this cycle's push, so an
  // empty-FIFO read returns 0 even when a beat lands in the same cycle.
  assign beat    = s_axis_tvalid && s_axis_tready && rx_en;
  assign pop_req = ar_hs && (s_axi_araddr[3:0] == ADDR_RXDR) && !empty;
  assign pop     = pop_req && !flush;
  assign push    = beat && (!full || pop_req) && !flush;
  assign ovf_set = beat && full && !pop_req && !flush;
  assign ovf_clr = wr_stat && s_axi_wstrb[0] && s_axi_wdata[2];

  // FIFO pointer, occupancy, overflow and interrupt next-state
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
    overflow_next = ovf_set || (overflow && !ovf_clr);
    irq_next = irq_en_next &&
               (((count_next != '0) && (count_next >= thresh_next)) || overflow_next);
  end

  // Register file, FIFO bookkeeping, interrupt and stream-ready state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      baud          <= '0;
      rx_en         <= 1'b0;
      irq_en        <= 1'b0;
      thresh        <= CW'(1);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      irq           <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      baud          <= baud_next;
      rx_en         <= rx_en_next;
      irq_en        <= irq_en_next;
      thresh        <= thresh_next;
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      count         <= count_next;
      overflow      <= overflow_next;
      irq           <= irq_next;
      s_axis_tready <= 1'b1;
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

  // Read data selection from the pre-update register state
  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:0])
      ADDR_CTRL: begin
        rd_mux[15:0] = baud;
        rd_mux[16]   = rx_en;
        rd_mux[17]   = irq_en;
      end
      ADDR_RXDR: begin
        if (!empty) begin
          rd_mux[C_RX_WIDTH-1:0]   = mem[rd_ptr];
          rd_mux[C_DATA_WIDTH-1]   = 1'b1;
        end
      end
      ADDR_STAT: begin
        rd_mux[0]      = empty;
        rd_mux[1]      = full;
        rd_mux[2]      = overflow;
        rd_mux[8 +: CW] = count;
      end
      ADDR_THRESH: rd_mux[CW-1:0] = thresh;
      default: rd_mux = '0;
    endcase
  end

  // Capture read data on the address handshake and hold it until the next one
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)     s_axi_rdata <= '0;
    else if (ar_hs) s_axi_rdata <= rd_mux;
  end

endmodule
